sd_spi_reader: RTL

SPI-mode byte reader for the SD card interface: clocks one byte (or a polled sequence of bytes) in from the card on MISO while holding MOSI high, and returns it to the controlling sequencer. It is the read-side counterpart of the command/byte writer. It is driven by the same four-phase start/finish handshake as the other SD helper blocks, so the sequencer can issue a read and then wait on finish. In response mode it polls for an R1 response byte, one whose MSB is 0.

---
 rtl/sd_spi_reader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sd_spi_reader.sv
// sd_spi_reader
//
// SPI mode-0 byte reader for an SD card. It clocks one byte in from the card
// on miso while holding mosi high (0xFF filler). In response mode it keeps
// reading bytes until it sees one whose MSB is 0 (an R1 response), or until
// POLL_LIMIT bytes have been read without one.
//
// Handshake (four-phase start/finish):
//   The sequencer raises start and holds it. The block accepts start in IDLE,
//   which clears finish and timeout. When the transfer ends, finish rises and
//   data/timeout become valid. The sequencer then drops start. The block goes
//   back to IDLE only after it has seen start low, so a start level that is
//   still held cannot launch a second transfer. finish stays high until the
//   next start is accepted.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      transfer request level
//   finish     transfer complete; data and timeout are valid while high
//   wait_resp  0: read one byte, 1: poll for an R1 byte (latched on accept)
//   sclk       SPI clock, idles low, registered
//   mosi       always 1, registered
//   miso       card data, MSB first, sampled on the edge that raises sclk
//   data       last byte received, updated only when finish rises
//   timeout    polling ran out of bytes without seeing MSB==0
//   state_dbg  current FSM state encoding, for observation only
module sd_spi_reader #(
    parameter int CLK_DIV    = 4,
    parameter int POLL_LIMIT = 8,
    parameter int POLL_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       finish,
    input  logic       wait_resp,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] data,
    output logic       timeout,
    output logic [2:0] state_dbg
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [POLL_WIDTH-1:0] POLL_LAST = POLL_WIDTH'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_q;
    logic [DIV_W-1:0]      div_q;
    logic [2:0]            bit_q;
    logic [POLL_WIDTH-1:0] poll_q;
    logic [7:0]            shift_q;
    logic [7:0]            data_q;
    logic                  wait_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  finish_q;
    logic                  timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            poll_q    <= '0;
            shift_q   <= '0;
            data_q    <= 8'h00;
            wait_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            finish_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            mosi_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= 1'b0;
                    div_q  <= '0;
                    bit_q  <= '0;
                    poll_q <= '0;
                    if (start) begin
                        finish_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        wait_q    <= wait_resp;
                        state_q   <= ST_LOW;
                    end
                end

                ST_LOW: begin
                    if (div_q == DIV_LAST) begin
                        // Rising sclk edge: the card has had the whole low
                        // phase to settle miso, so sample it here.
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        shift_q <= {shift_q[6:0], miso};
                        state_q <= ST_HIGH;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_CHECK;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            state_q <= ST_LOW;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                ST_CHECK: begin
                    sclk_q <= 1'b0;
                    if (!wait_q || !shift_q[7]) begin
                        data_q   <= shift_q;
                        finish_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (poll_q == POLL_LAST) begin
                        data_q    <= shift_q;
                        timeout_q <= 1'b1;
                        finish_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        // Card still busy (MSB set): clock another byte.
                        poll_q  <= poll_q + 1'b1;
                        bit_q   <= '0;
                        state_q <= ST_LOW;
                    end
                end

                ST_DONE: begin
                    sclk_q <= 1'b0;
                    if (!start) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    sclk_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign finish    = finish_q;
    assign timeout   = timeout_q;
    assign data      = data_q;
    assign state_dbg = state_q;

endmodule
